// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - toggle-vector sequencer driving a T flip-flop bank as a loadable up/down counter
//
// One run per start/done handshake: the bank is loaded with a start value and then
// stepped up or down, one step per cycle, until it equals a terminal value.
//
// Ports:
//   clk       rising-edge clock
//   clr       synchronous active-high reset
//   start     run request, sampled only in IDLE
//   up        direction latched at start (1 = up, 0 = down)
//   hold      live pause while counting
//   load_val  start value latched at start
//   limit     terminal value latched at start
//   t         toggle vector applied to the bank this cycle (combinational)
//   q         bank state (registered)
//   busy      high whenever not IDLE
//   done      one-cycle pulse while in DONE
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             up,
    input  logic             hold,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             up_r;
    logic [WIDTH-1:0] ld_r;
    logic [WIDTH-1:0] lim_r;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;

    // Bit i toggles when every lower bit is 1 (increment) or every lower bit
    // is 0 (decrement); built as a ripple of the running AND.
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        state_n = state;
        t       = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                // Toggle exactly the bits that differ so the bank lands on ld_r.
                t       = q ^ ld_r;
                state_n = S_COUNT;
            end
            S_COUNT: begin
                // Reaching the limit wins over hold so a held run still finishes.
                if (q == lim_r) begin
                    state_n = S_DONE;
                end else if (!hold) begin
                    t = up_r ? t_up : t_dn;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
            q     <= '0;
            up_r  <= 1'b0;
            ld_r  <= '0;
            lim_r <= '0;
        end else begin
            state <= state_n;
            q     <= q ^ t;
            if (state == S_IDLE && start) begin
                up_r  <= up;
                ld_r  <= load_val;
                lim_r <= limit;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - scoreboard bench for tff_count_ctrl
module tb_tff_count_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0;
    logic       up = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] limit = 4'd0;
    logic [3:0] t;
    logic [3:0] q;
    logic       busy;
    logic       done;

    tff_count_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .up       (up),
        .hold     (hold),
        .load_val (load_val),
        .limit    (limit),
        .t        (t),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       up;
        logic       hold;
        logic       clr;
        logic [3:0] ld;
        logic [3:0] lim;
    } stim_t;

    typedef struct {
        logic [3:0] q;
        logic [3:0] t;
        logic       busy;
        logic       done;
    } exp_t;

    stim_t      stim_q[$];
    exp_t       exp_q[$];
    logic [3:0] model_q = 4'd0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    // Plans one run starting with start in offset 0. hs/hl: hold window;
    // sdc: offset of a stray start with different operands; clr_at: offset
    // from which clr (and start) are held high; extra: trailing IDLE cycles.
    task automatic plan(input logic u, input logic [3:0] ld, input logic [3:0] lim,
                        input int hs, input int hl, input int sdc, input int clr_at,
                        input int extra);
        stim_t      s;
        exp_t       e;
        logic [3:0] mq;
        logic [3:0] nq;
        int         st;
        int         nst;
        int         c;
        int         idle_left;
        mq        = model_q;
        st        = 0;
        c         = 0;
        idle_left = extra;
        forever begin
            if (c > 0 && st == 0) begin
                if (idle_left == 0) break;
                idle_left--;
            end
            s.clr   = (clr_at >= 0 && c >= clr_at);
            s.start = (c == 0) || (c == sdc) || s.clr;
            s.hold  = (hs >= 0 && c >= hs && c < hs + hl);
            if (c == 0) begin
                s.up = u; s.ld = ld; s.lim = lim;
            end else if (c == sdc) begin
                s.up = ~u; s.ld = ~ld; s.lim = ~lim;
            end else begin
                s.up = 1'($urandom); s.ld = 4'($urandom); s.lim = 4'($urandom);
            end
            e.q    = mq;
            e.t    = 4'd0;
            e.busy = (st != 0);
            e.done = (st == 3);
            nq     = mq;
            nst    = st;
            case (st)
                0: if (c == 0) nst = 1;
                1: begin e.t = mq ^ ld; nq = ld; nst = 2; end
                2: begin
                    if (mq == lim) nst = 3;
                    else if (!s.hold) begin
                        nq  = u ? mq + 4'd1 : mq - 4'd1;
                        e.t = mq ^ nq;
                    end
                end
                default: nst = 0;
            endcase
            if (s.clr) begin
                nq  = 4'd0;
                nst = 0;
            end
            stim_q.push_back(s);
            exp_q.push_back(e);
            mq = nq;
            st = nst;
            c++;
        end
        model_q = mq;
    endtask

    task automatic run_all();
        stim_t s;
        exp_t  e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            s        = stim_q.pop_front();
            clr      = s.clr;
            start    = s.start;
            up       = s.up;
            hold     = s.hold;
            load_val = s.ld;
            limit    = s.lim;
            #1;
            e = exp_q.pop_front();
            check($sformatf("q@%0d", cyc), {28'd0, q}, {28'd0, e.q});
            check($sformatf("t@%0d", cyc), {28'd0, t}, {28'd0, e.t});
            check($sformatf("busy@%0d", cyc), {31'd0, busy}, {31'd0, e.busy});
            check($sformatf("done@%0d", cyc), {31'd0, done}, {31'd0, e.done});
            cyc++;
        end
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", {28'd0, q}, 32'd0);
        check("reset_t", {28'd0, t}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        model_q = 4'd0;

        plan(1'b1, 4'd3, 4'd7, -1, 0, -1, -1, 1);   // basic up count
        plan(1'b0, 4'd2, 4'd13, -1, 0, -1, -1, 1);  // down with wrap 0->15
        plan(1'b1, 4'd3, 4'd7, 4, 2, -1, -1, 1);    // hold at q=5 for two cycles
        plan(1'b1, 4'd9, 4'd9, -1, 0, -1, -1, 0);   // N=0, back-to-back next
        plan(1'b0, 4'd9, 4'd4, -1, 0, -1, -1, 1);
        plan(1'b1, 4'd2, 4'd10, -1, 0, 4, -1, 3);   // stray start mid-run
        plan(1'b1, 4'd3, 4'd7, -1, 0, -1, 4, 3);    // clr at q=5, start held with clr
        plan(1'b1, 4'd14, 4'd1, 3, 1, -1, -1, 1);   // up wrap 15->0 with hold
        plan(1'b0, 4'd5, 4'd5, 2, 3, -1, -1, 1);    // limit beats hold
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
